// File: rtl/l2_line_memory.sv
// L2-side backing line memory: 512-bit line write-backs and fills, serialized
// as 16 sequential 32-bit accesses to a single-port RAM with registered read.
module l2_line_memory #(
  parameter int          RAM_DEPTH = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_MEM,
  input  logic         we_MEM,
  input  logic [25:0]  address_MEM,
  input  logic [511:0] write_data_MEM,
  output logic         busy_MEM,
  output logic         ready_MEM_L2,
  output logic [511:0] read_data_MEM_L2
);

  localparam int          AW        = $clog2(RAM_DEPTH);
  localparam logic [25:0] BASE_LINE = BASE_ADDR[31:6];
  localparam logic [29:0] DEPTH_W   = 30'(RAM_DEPTH);

  typedef enum logic [2:0] {IDLE, WRITE, READ, RESP, RELEASE} state_t;

  state_t         state, state_next;
  logic [4:0]     cnt;
  logic [25:0]    line_r;
  logic [511:0]   wdata_r;
  logic [511:0]   read_data_r;
  logic [29:0]    waddr;
  logic           oob;
  logic           rd_oob_r;
  logic           ram_we;
  logic [31:0]    wr_word;
  logic [31:0]    ram_dout;
  logic [3:0]     word_idx;
  logic [31:0]    mem [RAM_DEPTH];

  // Subtraction wraps for lines below the base; the explicit compare catches it.
  assign waddr    = {line_r - BASE_LINE, cnt[3:0]};
  assign oob      = (line_r < BASE_LINE) | (waddr >= DEPTH_W);
  assign wr_word  = wdata_r[{cnt[3:0], 5'd0} +: 32];
  assign word_idx = 4'(cnt - 5'd1);
  // A reset edge must also block the write of the word in flight.
  assign ram_we   = (state == WRITE) && !oob && !rst;

  always_ff @(posedge clk) begin
    if (ram_we)
      mem[waddr[AW-1:0]] <= wr_word;
    if (state == READ)
      ram_dout <= mem[waddr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      line_r      <= '0;
      wdata_r     <= '0;
      rd_oob_r    <= 1'b0;
      read_data_r <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req_MEM) begin
            line_r  <= address_MEM;
            wdata_r <= write_data_MEM;
            cnt     <= '0;
          end
        end
        WRITE: cnt <= cnt + 5'd1;
        READ: begin
          cnt      <= cnt + 5'd1;
          rd_oob_r <= oob;
          // RAM data lags the address by one cycle, so word cnt-1 lands now.
          if (cnt != 5'd0)
            read_data_r[{word_idx, 5'd0} +: 32] <= rd_oob_r ? 32'h0 : ram_dout;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next   = state;
    busy_MEM     = 1'b1;
    ready_MEM_L2 = 1'b0;
    case (state)
      IDLE: begin
        busy_MEM = 1'b0;
        if (req_MEM)
          state_next = we_MEM ? WRITE : READ;
      end
      WRITE:   if (cnt == 5'd15) state_next = RESP;
      READ:    if (cnt == 5'd16) state_next = RESP;
      RESP: begin
        ready_MEM_L2 = 1'b1;
        state_next   = RELEASE;
      end
      RELEASE: if (!req_MEM) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign read_data_MEM_L2 = read_data_r;

endmodule

// File: tb/tb_l2_line_memory.sv
// Directed bench for l2_line_memory: table of line transactions plus
// hand-written sequences for held request, mid-write reset and input changes.
module tb_l2_line_memory;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_MEM;
  logic         we_MEM;
  logic [25:0]  address_MEM;
  logic [511:0] write_data_MEM;
  logic         busy_MEM;
  logic         ready_MEM_L2;
  logic [511:0] read_data_MEM_L2;

  int tests = 0;
  int fails = 0;

  l2_line_memory dut (
    .clk              (clk),
    .rst              (rst),
    .req_MEM          (req_MEM),
    .we_MEM           (we_MEM),
    .address_MEM      (address_MEM),
    .write_data_MEM   (write_data_MEM),
    .busy_MEM         (busy_MEM),
    .ready_MEM_L2     (ready_MEM_L2),
    .read_data_MEM_L2 (read_data_MEM_L2)
  );

  always #5 clk = ~clk;

  localparam logic [25:0] LINE_A    = 26'h040_0000;
  localparam logic [25:0] LINE_LAST = 26'h040_00FF;
  localparam logic [25:0] LINE_LOW  = 26'h03F_FFFF;
  localparam logic [25:0] LINE_HIGH = 26'h040_0100;

  typedef struct {
    logic         we;
    logic [25:0]  line;
    logic [511:0] data;
    int           exp_cyc;
    logic [511:0] exp_rd;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [511:0] pat(input logic [31:0] b, input int nwords);
    logic [511:0] p;
    p = '0;
    for (int k = 0; k < nwords; k++)
      p[32*k +: 32] = b + 32'(k);
    return p;
  endfunction

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a request and waits for ready; cyc counts edges from acceptance.
  task automatic run_req(input logic we, input logic [25:0] line, input logic [511:0] data,
                         output int cyc, output logic [511:0] rd);
    int n;
    req_MEM        = 1'b1;
    we_MEM         = we;
    address_MEM    = line;
    write_data_MEM = data;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ready_MEM_L2 && n < 40);
    cyc = ready_MEM_L2 ? n : -1;
    rd  = read_data_MEM_L2;
  endtask

  task automatic release_req();
    req_MEM = 1'b0;
    tick();
    check("ready_width", {511'b0, ready_MEM_L2}, 512'd0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    int           cyc;
    int           n;
    int           pulses;
    int           busy_low;
    logic [511:0] rd;

    vecs[0] = '{1'b1, LINE_A,    pat(32'hA5A5_0000, 16), 17, '0};
    vecs[1] = '{1'b0, LINE_A,    '0,                     18, pat(32'hA5A5_0000, 16)};
    vecs[2] = '{1'b0, LINE_LOW,  '0,                     18, '0};
    vecs[3] = '{1'b0, LINE_HIGH, '0,                     18, '0};
    vecs[4] = '{1'b1, LINE_LAST, pat(32'hB0B0_0000, 16), 17, '0};
    vecs[5] = '{1'b1, LINE_LOW,  pat(32'hEEEE_0000, 16), 17, '0};
    vecs[6] = '{1'b1, LINE_HIGH, pat(32'hFFFF_0000, 16), 17, '0};
    vecs[7] = '{1'b0, LINE_A,    '0,                     18, pat(32'hA5A5_0000, 16)};
    vecs[8] = '{1'b0, LINE_LAST, '0,                     18, pat(32'hB0B0_0000, 16)};

    rst = 1'b1; req_MEM = 1'b0; we_MEM = 1'b0; address_MEM = '0; write_data_MEM = '0;
    repeat (3) tick();
    check("reset_busy",  {511'b0, busy_MEM},     512'd0);
    check("reset_ready", {511'b0, ready_MEM_L2}, 512'd0);
    check("reset_rdata", read_data_MEM_L2,       512'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_req(vecs[i].we, vecs[i].line, vecs[i].data, cyc, rd);
      $display("[TB] vec %0d we=%0b line=%h ready_cycle=%0d", i, vecs[i].we, vecs[i].line, cyc);
      check($sformatf("vec%0d_cycles", i), 512'(cyc), 512'(vecs[i].exp_cyc));
      if (!vecs[i].we)
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      release_req();
    end

    // Held request: one pulse only, busy stays high until req drops.
    run_req(1'b0, LINE_A, '0, cyc, rd);
    pulses = (cyc > 0) ? 1 : 0;
    busy_low = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ready_MEM_L2) pulses++;
      if (!busy_MEM) busy_low++;
    end
    req_MEM = 1'b0;
    tick();
    $display("[TB] held req pulses=%0d busy_low=%0d", pulses, busy_low);
    check("held_pulses",   512'(pulses), 512'd1);
    check("held_busy_low", 512'(busy_low), 512'd0);
    check("held_idle",     {511'b0, busy_MEM}, 512'd0);

    // Reset mid-write: words 0..6 land, word 7 onward never written.
    run_req(1'b1, 26'h040_0010, '0, cyc, rd);
    release_req();
    req_MEM = 1'b1; we_MEM = 1'b1; address_MEM = 26'h040_0010;
    write_data_MEM = pat(32'hDEAD_0000, 16);
    tick();
    repeat (7) tick();
    rst = 1'b1; req_MEM = 1'b0;
    tick();
    check("rstmid_busy",  {511'b0, busy_MEM},     512'd0);
    check("rstmid_ready", {511'b0, ready_MEM_L2}, 512'd0);
    check("rstmid_rdata", read_data_MEM_L2,       512'd0);
    rst = 1'b0;
    pulses = 0;
    repeat (20) begin
      tick();
      if (ready_MEM_L2) pulses++;
    end
    check("rstmid_no_pulse", 512'(pulses), 512'd0);
    run_req(1'b0, 26'h040_0010, '0, cyc, rd);
    $display("[TB] rstmid fill ready_cycle=%0d", cyc);
    check("rstmid_fill_cycles", 512'(cyc), 512'd18);
    check("rstmid_fill_rdata",  rd, pat(32'hDEAD_0000, 7));
    release_req();

    // Inputs changed after acceptance and req dropped at cycle 5.
    run_req(1'b1, 26'h040_0030, '0, cyc, rd);
    release_req();
    req_MEM = 1'b1; we_MEM = 1'b1; address_MEM = 26'h040_0020;
    write_data_MEM = pat(32'h1234_0000, 16);
    tick();
    n = 1;
    address_MEM = 26'h040_0030; write_data_MEM = pat(32'h9999_0000, 16); we_MEM = 1'b0;
    repeat (4) begin
      tick();
      n++;
    end
    req_MEM = 1'b0;
    while (!ready_MEM_L2 && n < 40) begin
      tick();
      n++;
    end
    $display("[TB] change-after-accept ready_cycle=%0d", n);
    check("chg_cycles", 512'(n), 512'd17);
    release_req();
    run_req(1'b0, 26'h040_0020, '0, cyc, rd);
    check("chg_orig_line", rd, pat(32'h1234_0000, 16));
    release_req();
    run_req(1'b0, 26'h040_0030, '0, cyc, rd);
    check("chg_other_line", rd, 512'd0);
    release_req();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
